// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU results take
// absolute priority, long-unit results drain in order through a small FIFO.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_we,
    input  logic [ADDR_W-1:0]             alu_waddr,
    input  logic [DATA_W-1:0]             alu_wdata,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [ADDR_W-1:0]             lu_waddr,
    input  logic [DATA_W-1:0]             lu_wdata,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_addr,
    input  logic [ADDR_W-1:0]             chk_addr1,
    input  logic [ADDR_W-1:0]             chk_addr2,
    output logic                          chk_busy1,
    output logic                          chk_busy2,
    output logic                          we,
    output logic [ADDR_W-1:0]             waddr,
    output logic [DATA_W-1:0]             wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    logic              alu_sel;
    logic              fifo_ne;
    logic              lu_keep;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;

    always_comb begin
        lu_ready = !rst && (fifo_cnt < CNT_W'(FIFO_DEPTH));
        alu_sel  = alu_we && (alu_waddr != '0);
        fifo_ne  = (fifo_cnt != '0);
        // Results for r0 are accepted but neither buffered nor written.
        lu_keep  = lu_valid && lu_ready && (lu_waddr != '0);
        pop      = !alu_sel && fifo_ne;
        bypass   = !alu_sel && !fifo_ne && lu_keep;
        push     = lu_keep && !bypass;
    end

    always_comb begin
        clr_en   = 1'b0;
        clr_addr = '0;
        if (pop) begin
            clr_en   = 1'b1;
            clr_addr = fifo_addr[head];
        end else if (bypass) begin
            clr_en   = 1'b1;
            clr_addr = lu_waddr;
        end
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_addr] = 1'b0;
        // A same-cycle re-issue to the register being retired must stay pending.
        if (iss_valid && (iss_addr != '0))
            pending_nxt[iss_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign chk_busy1 = pending[chk_addr1];
    assign chk_busy2 = pending[chk_addr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            fifo_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            pending  <= '0;
        end else begin
            we <= alu_sel || pop || bypass;
            if (alu_sel) begin
                waddr <= alu_waddr;
                wdata <= alu_wdata;
            end else if (pop) begin
                waddr <= fifo_addr[head];
                wdata <= fifo_data[head];
            end else if (bypass) begin
                waddr <= lu_waddr;
                wdata <= lu_wdata;
            end
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= lu_waddr;
            fifo_data[tail] <= lu_wdata;
        end
    end

endmodule
